// File: rtl/mont_acc_pkg.sv
// rtl/mont_acc_pkg.sv - register offsets, bit indices and core FSM states for the Montgomery accelerator
package mont_acc_pkg;

    localparam logic [8:0] A_OFF    = 9'h000;
    localparam logic [8:0] B_OFF    = 9'h040;
    localparam logic [8:0] M_OFF    = 9'h080;
    localparam logic [8:0] R_OFF    = 9'h0C0;
    localparam logic [8:0] CTRL_OFF = 9'h100;
    localparam logic [8:0] STAT_OFF = 9'h104;

    localparam int CTRL_START = 0;
    localparam int CTRL_IE    = 1;
    localparam int STAT_BUSY  = 0;
    localparam int STAT_DONE  = 1;
    localparam int STAT_ERR   = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_LOOP  = 3'd2,
        ST_FIX   = 3'd3,
        ST_DONE  = 3'd4
    } mont_state_e;

endpackage

// File: rtl/mont_mul_core.sv
// rtl/mont_mul_core.sv - bit-serial radix-2 Montgomery multiplier, R = A*B*2^-W mod M
module mont_mul_core
    import mont_acc_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic         i_clr_done,
    input  logic         i_clr_err,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_m,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_err,
    output logic [W-1:0] o_r
);
    localparam int CW = $clog2(W);

    mont_state_e  r_state;
    logic [W-1:0] r_a, r_b, r_m, r_r;
    logic [W+1:0] r_t;
    logic [CW-1:0] r_cnt;
    logic         r_busy, r_done, r_err;
    logic [W+1:0] w_t_add, w_t_red;

    // r_a is shifted right each iteration so bit 0 is always the current A[i]
    always_comb begin
        w_t_add = r_t + (r_a[0] ? {2'b00, r_b} : '0);
        w_t_red = w_t_add + (w_t_add[0] ? {2'b00, r_m} : '0);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_m     <= '0;
            r_r     <= '0;
            r_t     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (i_clr_done) r_done <= 1'b0;
            if (i_clr_err)  r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_a     <= i_a;
                        r_b     <= i_b;
                        r_m     <= i_m;
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                        // an even (or zero) modulus is rejected without ever raising BUSY
                        r_busy  <= i_m[0];
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (!r_m[0]) begin
                        r_err   <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_t     <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_LOOP;
                    end
                end
                ST_LOOP: begin
                    r_t   <= w_t_red >> 1;
                    r_a   <= r_a >> 1;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(W - 1)) r_state <= ST_FIX;
                end
                ST_FIX: begin
                    r_r     <= (r_t >= {2'b00, r_m}) ? W'(r_t - {2'b00, r_m}) : r_t[W-1:0];
                    r_busy  <= 1'b0;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_err  = r_err;
    assign o_r    = r_r;

endmodule

// File: rtl/ahb_mont_mul_acc.sv
// rtl/ahb_mont_mul_acc.sv - AHB-Lite Montgomery multiply accelerator; MONT_IRQ_EN adds IRQ and CTRL.IE
module ahb_mont_mul_acc
    import mont_acc_pkg::*;
#(
    parameter int W = 32
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic        HREADY,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic        HWRITE,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP,
    output logic [31:0] HRDATA
`ifdef MONT_IRQ_EN
    ,
    output logic        IRQ
`endif
);
    localparam int NW = W / 32;

    logic         r_acc, r_write;
    logic [8:0]   r_addr;
    logic [W-1:0] r_a, r_b, r_m;
    logic [W-1:0] w_r;
    logic         w_busy, w_done, w_err;
    logic [2:0]   w_region;
    logic [3:0]   w_idx;
    logic         w_word_ok, w_in_a, w_in_b, w_in_m, w_in_r, w_ctrl, w_stat;
    logic         w_wr, w_rd, w_wr_ok, w_start, w_clr_done, w_clr_err;
    logic [31:0]  w_ctrl_rd;
    logic         w_unused;

    assign HREADYOUT = 1'b1;
    assign HRESP     = 2'b00;
    assign w_unused  = ^{HSIZE, HADDR[31:9], HTRANS[0]};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_acc   <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= '0;
        end else if (HREADY) begin
            r_acc   <= HSEL & HTRANS[1];
            r_write <= HWRITE;
            r_addr  <= HADDR[8:0];
        end
    end

    assign w_region  = r_addr[8:6];
    assign w_idx     = r_addr[5:2];
    assign w_word_ok = int'(w_idx) < NW;
    assign w_in_a    = w_region == A_OFF[8:6];
    assign w_in_b    = w_region == B_OFF[8:6];
    assign w_in_m    = w_region == M_OFF[8:6];
    assign w_in_r    = w_region == R_OFF[8:6];
    assign w_ctrl    = r_addr == CTRL_OFF;
    assign w_stat    = r_addr == STAT_OFF;
    assign w_wr      = r_acc & r_write;
    assign w_rd      = r_acc & ~r_write;
    assign w_wr_ok   = w_wr & ~w_busy & w_word_ok;
    assign w_start   = w_wr & ~w_busy & w_ctrl & HWDATA[CTRL_START];
    assign w_clr_done = w_wr & w_stat & HWDATA[STAT_DONE];
    assign w_clr_err  = w_wr & w_stat & HWDATA[STAT_ERR];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_a <= '0;
            r_b <= '0;
            r_m <= '0;
        end else begin
            for (int k = 0; k < NW; k++) begin
                if (w_wr_ok && int'(w_idx) == k) begin
                    if (w_in_a) r_a[k*32 +: 32] <= HWDATA;
                    if (w_in_b) r_b[k*32 +: 32] <= HWDATA;
                    if (w_in_m) r_m[k*32 +: 32] <= HWDATA;
                end
            end
        end
    end

`ifdef MONT_IRQ_EN
    logic r_ie, r_irq;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_ie  <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            if (w_wr && !w_busy && w_ctrl) r_ie <= HWDATA[CTRL_IE];
            r_irq <= r_ie & (w_done | w_err);
        end
    end

    assign IRQ       = r_irq;
    assign w_ctrl_rd = {30'd0, r_ie, 1'b0};
`else
    assign w_ctrl_rd = '0;
`endif

    always_comb begin
        HRDATA = '0;
        if (w_rd) begin
            for (int k = 0; k < NW; k++) begin
                if (int'(w_idx) == k) begin
                    if (w_in_a) HRDATA = r_a[k*32 +: 32];
                    if (w_in_b) HRDATA = r_b[k*32 +: 32];
                    if (w_in_m) HRDATA = r_m[k*32 +: 32];
                    if (w_in_r) HRDATA = w_r[k*32 +: 32];
                end
            end
            if (w_ctrl) HRDATA = w_ctrl_rd;
            if (w_stat) HRDATA = {29'd0, w_err, w_done, w_busy};
        end
    end

    mont_mul_core #(.W(W)) u_core (
        .i_clk      (HCLK),
        .i_rst_n    (HRESETn),
        .i_start    (w_start),
        .i_clr_done (w_clr_done),
        .i_clr_err  (w_clr_err),
        .i_a        (r_a),
        .i_b        (r_b),
        .i_m        (r_m),
        .o_busy     (w_busy),
        .o_done     (w_done),
        .o_err      (w_err),
        .o_r        (w_r)
    );

endmodule

// File: tb/tb_ahb_mont_mul_acc.sv
// tb/tb_ahb_mont_mul_acc.sv - bench for ahb_mont_mul_acc at W=32 and W=64
module tb_ahb_mont_mul_acc;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        hsel;
    logic        HREADY = 1'b1;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE = 3'b010;
    logic        HWRITE;
    logic [31:0] HADDR, HWDATA;
    int          cur;
    logic        hsel0, hsel1, hro0, hro1;
    logic [1:0]  hresp0, hresp1;
    logic [31:0] rd0, rd1, rdata;
`ifdef MONT_IRQ_EN
    logic        irq0, irq1;
`endif

    always #5 HCLK = ~HCLK;

    assign hsel0 = hsel && (cur == 0);
    assign hsel1 = hsel && (cur == 1);
    assign rdata = (cur == 0) ? rd0 : rd1;

    ahb_mont_mul_acc #(.W(32)) u_dut32 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel0), .HREADY(HREADY), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HWRITE(HWRITE), .HADDR(HADDR), .HWDATA(HWDATA),
        .HREADYOUT(hro0), .HRESP(hresp0), .HRDATA(rd0)
`ifdef MONT_IRQ_EN
        , .IRQ(irq0)
`endif
    );

    ahb_mont_mul_acc #(.W(64)) u_dut64 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel1), .HREADY(HREADY), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HWRITE(HWRITE), .HADDR(HADDR), .HWDATA(HWDATA),
        .HREADYOUT(hro1), .HRESP(hresp1), .HRDATA(rd1)
`ifdef MONT_IRQ_EN
        , .IRQ(irq1)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // A*B*2^-w mod m: reduce the product, then halve w times in the ring mod m (m odd)
    function automatic logic [63:0] mont_ref(input logic [63:0] a, input logic [63:0] b,
                                             input logic [63:0] m, input int w);
        logic [127:0] x, mm;
        mm = {64'd0, m};
        x  = ({64'd0, a} * {64'd0, b}) % mm;
        for (int i = 0; i < w; i++) x = x[0] ? (x + mm) >> 1 : x >> 1;
        return x[63:0];
    endfunction

    task automatic idle();
        hsel = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        hsel = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
        @(posedge HCLK); #1;
        idle(); HWDATA = d;
        @(posedge HCLK); #1;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        hsel = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
        @(posedge HCLK); #1;
        idle(); d = rdata;
    endtask

    task automatic load(input logic [63:0] a, input logic [63:0] b, input logic [63:0] m, input int nw);
        for (int k = 0; k < nw; k++) begin
            wr(32'h000 + 32'(k * 4), a[k*32 +: 32]);
            wr(32'h040 + 32'(k * 4), b[k*32 +: 32]);
            wr(32'h080 + 32'(k * 4), m[k*32 +: 32]);
        end
    endtask

    // START write whose data phase overlaps the address phase of a STATUS read
    task automatic start_pipe(input logic [31:0] ctrl);
        hsel = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h100;
        @(posedge HCLK); #1;
        HWDATA = ctrl; HWRITE = 1'b0; HADDR = 32'h104;
    endtask

    // back-to-back STATUS reads; sample n is the status n cycles after the START took effect
    task automatic poll(output int lat, output int busy_n, output logic [31:0] st);
        hsel = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h104;
        lat = -1; busy_n = 0; st = '0;
        for (int n = 0; n < 200; n++) begin
            @(posedge HCLK); #1;
            st = rdata;
            if (st[0]) busy_n++;
            if (st[1] || st[2]) begin
                lat = n;
                break;
            end
        end
        idle();
    endtask

    logic [31:0] d, st;
    logic [63:0] ra, rb, rm, exp_r;
    int          lat, bn;

    initial begin
        idle(); HADDR = '0; HWDATA = '0; cur = 0; HRESETn = 1'b0;
        repeat (3) @(posedge HCLK);
        #1 HRESETn = 1'b1;
        @(posedge HCLK); #1;

        chk("hreadyout", {hro1, hro0}, 2'b11);
        chk("hresp", {hresp1, hresp0}, 4'b0000);
        chk("rst_idle_hrdata", rdata, 0);
        rd(32'h104, d); chk("rst_status", d, 0);
        rd(32'h0C0, d); chk("rst_result", d, 0);
        rd(32'h000, d); chk("rst_a", d, 0);

        // case 1
        load(5, 7, 13, 1);
        rd(32'h080, d); chk("m_readback", d, 13);
        start_pipe(32'h1); poll(lat, bn, st);
        chk("c1_latency", lat, 35);
        chk("c1_busy_cycles", bn, 34);
        chk("c1_status", st, 32'h2);
        rd(32'h0C0, d); chk("c1_result", d, 1);

        // case 2: START while DONE is still set; DONE must stay low until the new run ends
        load(12, 12, 13, 1);
        start_pipe(32'h1); poll(lat, bn, st);
        chk("c2_latency", lat, 35);
        rd(32'h0C0, d); chk("c2_result", d, 3);

        // case 3: even modulus
        wr(32'h080, 12);
        start_pipe(32'h1); poll(lat, bn, st);
        chk("c3_err_latency", lat, 1);
        chk("c3_busy_cycles", bn, 0);
        chk("c3_status", st, 32'h4);
        rd(32'h0C0, d); chk("c3_result_kept", d, 3);
        wr(32'h104, 32'h4);
        rd(32'h104, d); chk("c3_err_cleared", d, 0);

        // case 4: writes while busy are dropped
        load(5, 7, 13, 1);
        wr(32'h100, 32'h1);
        wr(32'h000, 32'hFFFF_FFFF);
        wr(32'h100, 32'h1);
        wr(32'h104, 32'h6);
        poll(lat, bn, st);
        chk("c4_status", st, 32'h2);
        rd(32'h0C0, d); chk("c4_result", d, 1);
        rd(32'h000, d); chk("c4_a_kept", d, 5);
        repeat (5) @(posedge HCLK);
        #1 rd(32'h104, d); chk("c4_no_rerun", d, 32'h2);

        // case 5: W=64
        cur = 1;
        load(5, 7, 13, 2);
        start_pipe(32'h1); poll(lat, bn, st);
        chk("c5_latency", lat, 67);
        chk("c5_busy_cycles", bn, 66);
        rd(32'h0C0, d); chk("c5_result_w0", d, 3);
        rd(32'h0C4, d); chk("c5_result_w1", d, 0);

        // random operands against the reference model
        for (int r = 0; r < 6; r++) begin
            cur = 0;
            rm = {32'd0, $urandom | 32'h1};
            ra = {32'd0, $urandom} % rm;
            rb = {32'd0, $urandom} % rm;
            exp_r = mont_ref(ra, rb, rm, 32);
            load(ra, rb, rm, 1);
            start_pipe(32'h1); poll(lat, bn, st);
            chk("rnd32_latency", lat, 35);
            rd(32'h0C0, d); chk("rnd32_result", d, exp_r[31:0]);
        end
        for (int r = 0; r < 4; r++) begin
            cur = 1;
            rm = {$urandom, $urandom} | 64'h1;
            ra = {$urandom, $urandom} % rm;
            rb = {$urandom, $urandom} % rm;
            exp_r = mont_ref(ra, rb, rm, 64);
            load(ra, rb, rm, 2);
            start_pipe(32'h1); poll(lat, bn, st);
            chk("rnd64_latency", lat, 67);
            rd(32'h0C0, d); chk("rnd64_result_w0", d, exp_r[31:0]);
            rd(32'h0C4, d); chk("rnd64_result_w1", d, exp_r[63:32]);
        end

        // case 6: reset during the loop
        cur = 0;
        load(5, 7, 13, 1);
        start_pipe(32'h1);
        @(posedge HCLK); #1 idle();
        repeat (10) @(posedge HCLK);
        #3 HRESETn = 1'b0;
        @(negedge HCLK) HRESETn = 1'b1;
        @(posedge HCLK); #1;
        rd(32'h104, d); chk("c6_status", d, 0);
        rd(32'h0C0, d); chk("c6_result", d, 0);
        rd(32'h000, d); chk("c6_a", d, 0);

`ifdef MONT_IRQ_EN
        load(5, 7, 13, 1);
        wr(32'h100, 32'h2);
        rd(32'h100, d); chk("irq_ie_readback", d, 32'h2);
        start_pipe(32'h3); poll(lat, bn, st);
        chk("irq_latency", lat, 35);
        chk("irq_not_yet", irq0, 1'b0);
        @(posedge HCLK); #1;
        chk("irq_asserted", irq0, 1'b1);
        wr(32'h104, 32'h2);
        @(posedge HCLK); #1;
        chk("irq_cleared", irq0, 1'b0);
`else
        wr(32'h100, 32'h2);
        rd(32'h100, d); chk("ctrl_ie_absent", d, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
